// File: rtl/as65_riot.sv
// -----------------------------------------------------------------------------
// as65_riot
//
// Memory-mapped I/O peripheral for the as65x CPU bus. It provides:
//   - two 8-bit bidirectional ports (A and B), each with an output register
//     and a data-direction register,
//   - an 8-bit interval timer with a 1/8/64/1024 prescale that free-runs at
//     clock rate after its first underflow,
//   - a PA7 edge detector with selectable polarity,
//   - an active-low IRQ combining the timer flag and the edge flag.
// The block completes one bus transaction per clk_i cycle. Reads are purely
// combinational and have no side effects. Writes commit on the rising edge.
//
// Register map (a_i):
//   0 ORA / port A data   1 DDRA     2 ORB / port B data   3 DDRB
//   4 TIMER (read-only)   5 IFR {TF,EF} (write-1-to-clear)
//   6 IER {TE,EE}         7 EDGE {POL}
//   8-B read TIMER, writes ignored
//   C-F read TIMER, write loads TIMER with prescale 1/8/64/1024
//
// Ports:
//   clk_i    bus clock, all state changes on its rising edge
//   rst_i    asynchronous active-high reset
//   cs_i     chip select for the current bus cycle
//   rwn_i    1 = read, 0 = write
//   a_i      register address
//   d_i      write data
//   d_o      read data (combinational)
//   d_oe     read-data drive enable (cs_i & rwn_i)
//   pa_i     port A pad inputs (asynchronous, synchronised here)
//   pa_o     port A output register
//   pa_oe    port A output enables (DDRA)
//   pb_i     port B pad inputs (asynchronous, synchronised here)
//   pb_o     port B output register
//   pb_oe    port B output enables (DDRB)
//   irq_n_o  active-low interrupt request
// -----------------------------------------------------------------------------
module as65_riot (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       cs_i,
   input  logic       rwn_i,
   input  logic [3:0] a_i,
   input  logic [7:0] d_i,
   output logic [7:0] d_o,
   output logic       d_oe,
   input  logic [7:0] pa_i,
   output logic [7:0] pa_o,
   output logic [7:0] pa_oe,
   input  logic [7:0] pb_i,
   output logic [7:0] pb_o,
   output logic [7:0] pb_oe,
   output logic       irq_n_o
);

   // Prescale selection; the encoding matches a_i[1:0] of a timer load.
   typedef enum logic [1:0] {
      PS_1    = 2'd0,
      PS_8    = 2'd1,
      PS_64   = 2'd2,
      PS_1024 = 2'd3
   } presc_e;

   localparam logic [3:0] A_ORA  = 4'h0;
   localparam logic [3:0] A_DDRA = 4'h1;
   localparam logic [3:0] A_ORB  = 4'h2;
   localparam logic [3:0] A_DDRB = 4'h3;
   localparam logic [3:0] A_TMR  = 4'h4;
   localparam logic [3:0] A_IFR  = 4'h5;
   localparam logic [3:0] A_IER  = 4'h6;
   localparam logic [3:0] A_EDGE = 4'h7;

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic [7:0] ora_q,   ora_d;
   logic [7:0] ddra_q,  ddra_d;
   logic [7:0] orb_q,   orb_d;
   logic [7:0] ddrb_q,  ddrb_d;

   logic [7:0] timer_q, timer_d;
   logic [9:0] pc_q,    pc_d;
   presc_e     presc_q, presc_d;
   logic       run_q,   run_d;

   logic       tf_q,    tf_d;
   logic       ef_q,    ef_d;
   logic       te_q,    te_d;
   logic       ee_q,    ee_d;
   logic       pol_q,   pol_d;

   // Pad synchronisers: *_m_q is the metastability stage, *_s_q is usable.
   logic [7:0] pa_m_q, pa_s_q;
   logic [7:0] pb_m_q, pb_s_q;
   logic       pa7_d_q;

   // ---------------------------------------------------------------------
   // Decode and helpers
   // ---------------------------------------------------------------------
   logic       wr_en;
   logic       timer_load;
   logic [9:0] pc_last;
   logic       pc_wrap;
   logic       pa7_rise;
   logic       pa7_fall;
   logic       edge_hit;

   assign wr_en      = cs_i & ~rwn_i;
   assign timer_load = wr_en & (a_i[3:2] == 2'b11);

   // Terminal prescale count for the active N.
   always_comb begin
      pc_last = 10'd1023;
      case (presc_q)
         PS_1:    pc_last = 10'd0;
         PS_8:    pc_last = 10'd7;
         PS_64:   pc_last = 10'd63;
         PS_1024: pc_last = 10'd1023;
         default: pc_last = 10'd1023;
      endcase
   end

   assign pc_wrap = run_q & (pc_q == pc_last);

   // pa7_d_q holds the previous synchronised PA7, so the pair spans one edge.
   assign pa7_rise = pa_s_q[7] & ~pa7_d_q;
   assign pa7_fall = ~pa_s_q[7] & pa7_d_q;
   assign edge_hit = pol_q ? pa7_rise : pa7_fall;

   // ---------------------------------------------------------------------
   // Next-state logic. Statement order encodes same-edge priority:
   // W1C clears first, flag sets override them, and a timer load
   // overrides everything the running timer would have done.
   // ---------------------------------------------------------------------
   always_comb begin
      // NOTE: every next-state signal is defaulted to its current value up
      // front, so no branch can leave it unassigned and infer a latch.
      ora_d   = ora_q;
      ddra_d  = ddra_q;
      orb_d   = orb_q;
      ddrb_d  = ddrb_q;
      timer_d = timer_q;
      pc_d    = pc_q;
      presc_d = presc_q;
      run_d   = run_q;
      tf_d    = tf_q;
      ef_d    = ef_q;
      te_d    = te_q;
      ee_d    = ee_q;
      pol_d   = pol_q;

      if (wr_en) begin
         case (a_i)
            A_ORA:  ora_d  = d_i;
            A_DDRA: ddra_d = d_i;
            A_ORB:  orb_d  = d_i;
            A_DDRB: ddrb_d = d_i;
            A_IFR: begin
               if (d_i[7]) tf_d = 1'b0;
               if (d_i[6]) ef_d = 1'b0;
            end
            A_IER: begin
               te_d = d_i[7];
               ee_d = d_i[6];
            end
            A_EDGE: pol_d = d_i[0];
            default: ;
         endcase
      end

      if (run_q) begin
         if (pc_wrap) begin
            pc_d = 10'd0;
            if (timer_q == 8'h00) begin
               // Underflow: wrap and switch to clock-rate counting.
               timer_d = 8'hFF;
               tf_d    = 1'b1;
               presc_d = PS_1;
            end else begin
               timer_d = timer_q - 8'd1;
            end
         end else begin
            pc_d = pc_q + 10'd1;
         end
      end

      if (edge_hit) ef_d = 1'b1;

      if (timer_load) begin
         timer_d = d_i;
         pc_d    = 10'd0;
         presc_d = presc_e'(a_i[1:0]);
         run_d   = 1'b1;
         tf_d    = 1'b0;
      end
   end

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of every other flop, independent of order.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ora_q   <= 8'h00;
         ddra_q  <= 8'h00;
         orb_q   <= 8'h00;
         ddrb_q  <= 8'h00;
         timer_q <= 8'h00;
         pc_q    <= 10'd0;
         presc_q <= PS_1024;
         run_q   <= 1'b0;
         tf_q    <= 1'b0;
         ef_q    <= 1'b0;
         te_q    <= 1'b0;
         ee_q    <= 1'b0;
         pol_q   <= 1'b0;
      end else begin
         ora_q   <= ora_d;
         ddra_q  <= ddra_d;
         orb_q   <= orb_d;
         ddrb_q  <= ddrb_d;
         timer_q <= timer_d;
         pc_q    <= pc_d;
         presc_q <= presc_d;
         run_q   <= run_d;
         tf_q    <= tf_d;
         ef_q    <= ef_d;
         te_q    <= te_d;
         ee_q    <= ee_d;
         pol_q   <= pol_d;
      end
   end

   // Synchronisers are reset too, so no stale pad history can fake a PA7
   // edge right after reset is released.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pa_m_q  <= 8'h00;
         pa_s_q  <= 8'h00;
         pb_m_q  <= 8'h00;
         pb_s_q  <= 8'h00;
         pa7_d_q <= 1'b0;
      end else begin
         pa_m_q  <= pa_i;
         pa_s_q  <= pa_m_q;
         pb_m_q  <= pb_i;
         pb_s_q  <= pb_m_q;
         pa7_d_q <= pa_s_q[7];
      end
   end

   // ---------------------------------------------------------------------
   // Read path and outputs
   // ---------------------------------------------------------------------
   assign d_oe = cs_i & rwn_i;

   // Port data reads return the output register on output bits and the
   // synchronised pad on input bits.
   always_comb begin
      d_o = timer_q;
      case (a_i)
         A_ORA:  d_o = (ddra_q & ora_q) | (~ddra_q & pa_s_q);
         A_DDRA: d_o = ddra_q;
         A_ORB:  d_o = (ddrb_q & orb_q) | (~ddrb_q & pb_s_q);
         A_DDRB: d_o = ddrb_q;
         A_TMR:  d_o = timer_q;
         A_IFR:  d_o = {tf_q, ef_q, 6'b0};
         A_IER:  d_o = {te_q, ee_q, 6'b0};
         A_EDGE: d_o = {7'b0, pol_q};
         default: d_o = timer_q;
      endcase
   end

   assign pa_o    = ora_q;
   assign pa_oe   = ddra_q;
   assign pb_o    = orb_q;
   assign pb_oe   = ddrb_q;
   assign irq_n_o = ~((tf_q & te_q) | (ef_q & ee_q));

endmodule

// File: tb/tb_as65_riot.sv
// -----------------------------------------------------------------------------
// tb_as65_riot
//
// Self-checking bench for as65_riot. The stimulus process drives one bus cycle
// per clock and, from a behavioural model, pushes the outputs the block must
// show in that cycle into a scoreboard queue. A separate monitor pops one
// entry per cycle on the falling edge and compares it with the DUT.
//
// The model keeps the timer as "load edge, load value, prescale" and derives
// the current count and the underflow edges arithmetically; pads are kept as
// a short history of per-edge samples.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_as65_riot;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic       cs_i;
   logic       rwn_i;
   logic [3:0] a_i;
   logic [7:0] d_i;
   logic [7:0] d_o;
   logic       d_oe;
   logic [7:0] pa_i;
   logic [7:0] pa_o;
   logic [7:0] pa_oe;
   logic [7:0] pb_i;
   logic [7:0] pb_o;
   logic [7:0] pb_oe;
   logic       irq_n_o;

   always #5 clk_i = ~clk_i;

   as65_riot dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .cs_i    (cs_i),
      .rwn_i   (rwn_i),
      .a_i     (a_i),
      .d_i     (d_i),
      .d_o     (d_o),
      .d_oe    (d_oe),
      .pa_i    (pa_i),
      .pa_o    (pa_o),
      .pa_oe   (pa_oe),
      .pb_i    (pb_i),
      .pb_o    (pb_o),
      .pb_oe   (pb_oe),
      .irq_n_o (irq_n_o)
   );

   // ---------------------------------------------------------------------
   // Scoreboard
   // ---------------------------------------------------------------------
   typedef struct {
      logic       doe;
      logic [7:0] d;
      logic       irq_n;
      logic [7:0] pa_o;
      logic [7:0] pa_oe;
      logic [7:0] pb_o;
      logic [7:0] pb_oe;
   } exp_t;

   exp_t sb_q[$];
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at t=%0t: got %02h expected %02h", name, $time, act, exp);
      end
   endtask

   // ---------------------------------------------------------------------
   // Behavioural model
   // ---------------------------------------------------------------------
   logic [7:0] m_ora, m_ddra, m_orb, m_ddrb;
   logic       m_tf, m_ef, m_te, m_ee, m_pol, m_run;
   int         m_edge;   // index of the most recent clock edge
   int         m_t0;     // edge at which the timer was last loaded
   int         m_d;      // value loaded
   int         m_n;      // prescale chosen at load
   logic [7:0] pa_hist[3];  // [0] = pad sampled at latest edge, [1] one before ...
   logic [7:0] pb_hist[3];

   function automatic int n_of(input logic [1:0] sel);
      case (sel)
         2'd0:    return 1;
         2'd1:    return 8;
         2'd2:    return 64;
         default: return 1024;
      endcase
   endfunction

   // Timer value after edge m_edge: D - floor(e/N) until the underflow at
   // e = (D+1)*N, then 0xFF counting down once per edge, modulo 256.
   function automatic logic [7:0] m_timer();
      int e, u0;
      if (!m_run) return 8'h00;
      e  = m_edge - m_t0;
      u0 = (m_d + 1) * m_n;
      if (e < u0) return 8'(m_d - e / m_n);
      return 8'(255 - ((e - u0) % 256));
   endfunction

   function automatic logic [7:0] m_read(input logic [3:0] a);
      // The port pin seen by a read was sampled two edges before it settles.
      case (a)
         4'h0:    return (m_ddra & m_ora) | (~m_ddra & pa_hist[1]);
         4'h1:    return m_ddra;
         4'h2:    return (m_ddrb & m_orb) | (~m_ddrb & pb_hist[1]);
         4'h3:    return m_ddrb;
         4'h5:    return {m_tf, m_ef, 6'b0};
         4'h6:    return {m_te, m_ee, 6'b0};
         4'h7:    return {7'b0, m_pol};
         default: return m_timer();
      endcase
   endfunction

   task automatic m_reset();
      m_ora = 8'h00; m_ddra = 8'h00; m_orb = 8'h00; m_ddrb = 8'h00;
      m_tf = 1'b0; m_ef = 1'b0; m_te = 1'b0; m_ee = 1'b0; m_pol = 1'b0;
      m_run = 1'b0; m_edge = 0; m_t0 = 0; m_d = 0; m_n = 1024;
      for (int i = 0; i < 3; i++) begin
         pa_hist[i] = 8'h00;
         pb_hist[i] = 8'h00;
      end
   endtask

   task automatic m_edge_step(input logic cs, input logic rwn, input logic [3:0] a,
                              input logic [7:0] d, input logic [7:0] pa, input logic [7:0] pb);
      int   ne, e, u0;
      logic uf, rise, fall, ev, wr;
      ne = m_edge + 1;
      uf = 1'b0;
      if (m_run) begin
         e  = ne - m_t0;
         u0 = (m_d + 1) * m_n;
         uf = (e >= u0) && (((e - u0) % 256) == 0);
      end
      rise = pa_hist[1][7] && !pa_hist[2][7];
      fall = !pa_hist[1][7] && pa_hist[2][7];
      ev   = m_pol ? rise : fall;
      wr   = cs && !rwn;

      if (wr && a == 4'h5 && d[7]) m_tf = 1'b0;
      if (wr && a == 4'h5 && d[6]) m_ef = 1'b0;
      if (uf) m_tf = 1'b1;
      if (ev) m_ef = 1'b1;
      if (wr) begin
         case (a)
            4'h0: m_ora  = d;
            4'h1: m_ddra = d;
            4'h2: m_orb  = d;
            4'h3: m_ddrb = d;
            4'h6: begin m_te = d[7]; m_ee = d[6]; end
            4'h7: m_pol = d[0];
            default: ;
         endcase
         if (a >= 4'hC) begin
            m_run = 1'b1;
            m_t0  = ne;
            m_d   = int'(d);
            m_n   = n_of(a[1:0]);
            m_tf  = 1'b0;
         end
      end
      pa_hist[2] = pa_hist[1]; pa_hist[1] = pa_hist[0]; pa_hist[0] = pa;
      pb_hist[2] = pb_hist[1]; pb_hist[1] = pb_hist[0]; pb_hist[0] = pb;
      m_edge = ne;
   endtask

   task automatic push_exp(input logic cs, input logic rwn, input logic [3:0] a);
      exp_t x;
      x.doe   = cs & rwn;
      x.d     = m_read(a);
      x.irq_n = !((m_tf && m_te) || (m_ef && m_ee));
      x.pa_o  = m_ora;
      x.pa_oe = m_ddra;
      x.pb_o  = m_orb;
      x.pb_oe = m_ddrb;
      sb_q.push_back(x);
   endtask

   // ---------------------------------------------------------------------
   // Stimulus helpers (entered and left #1 after a rising edge)
   // ---------------------------------------------------------------------
   task automatic bus(input logic cs, input logic rwn, input logic [3:0] a, input logic [7:0] d);
      cs_i = cs; rwn_i = rwn; a_i = a; d_i = d;
      push_exp(cs, rwn, a);
      @(posedge clk_i);
      m_edge_step(cs, rwn, a, d, pa_i, pb_i);
      #1;
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] d);
      bus(1'b1, 1'b0, a, d);
   endtask

   task automatic rd(input logic [3:0] a);
      bus(1'b1, 1'b1, a, 8'h00);
   endtask

   task automatic idle();
      bus(1'b0, 1'b1, 4'h0, 8'h00);
   endtask

   // Reset asserted mid-cycle; its effect must be visible before any edge.
   task automatic do_reset();
      rst_i = 1'b1; cs_i = 1'b0; rwn_i = 1'b1; a_i = 4'h0; d_i = 8'h00;
      m_reset();
      repeat (2) begin
         push_exp(1'b0, 1'b1, 4'h0);
         @(posedge clk_i);
         #1;
      end
      rst_i = 1'b0;
   endtask

   // ---------------------------------------------------------------------
   // Monitor
   // ---------------------------------------------------------------------
   initial begin
      exp_t x;
      forever begin
         @(negedge clk_i);
         if (sb_q.size() > 0) begin
            x = sb_q.pop_front();
            check("d_oe", 8'(d_oe), 8'(x.doe));
            if (x.doe) check("d_o", d_o, x.d);
            check("irq_n_o", 8'(irq_n_o), 8'(x.irq_n));
            check("pa_o", pa_o, x.pa_o);
            check("pa_oe", pa_oe, x.pa_oe);
            check("pb_o", pb_o, x.pb_o);
            check("pb_oe", pb_oe, x.pb_oe);
         end
      end
   end

   // ---------------------------------------------------------------------
   // Test sequence
   // ---------------------------------------------------------------------
   initial begin
      rst_i = 1'b1; cs_i = 1'b0; rwn_i = 1'b1; a_i = 4'h0; d_i = 8'h00;
      pa_i = 8'h00; pb_i = 8'h00;
      m_reset();
      @(posedge clk_i);
      #1;
      do_reset();

      // Reset in the middle of a count, then a long quiet stretch.
      wr(4'h1, 8'hFF);
      wr(4'h0, 8'h5A);
      wr(4'hF, 8'h40);
      repeat (5) rd(4'h4);
      do_reset();
      for (int i = 0; i < 2000; i++) rd(4'(i));

      // Port A mixed direction.
      wr(4'h1, 8'hF0);
      wr(4'h0, 8'hA5);
      pa_i = 8'h3C;
      idle();
      idle();
      rd(4'h0);
      pb_i = 8'h96;
      wr(4'h3, 8'h0F);
      wr(4'h2, 8'h33);
      idle();
      rd(4'h2);

      // Timer N = 8, D = 3, through underflow into free-run.
      wr(4'hD, 8'h03);
      wr(4'h6, 8'h80);
      for (int i = 0; i < 44; i++) rd((i % 3 == 2) ? 4'h5 : 4'h4);

      // Load on the underflow edge wins.
      wr(4'h5, 8'hC0);
      wr(4'hC, 8'h02);
      idle();
      idle();
      wr(4'hC, 8'h77);
      rd(4'h4);
      rd(4'h5);

      // W1C of TF on the underflow edge loses.
      wr(4'hC, 8'h02);
      idle();
      idle();
      wr(4'h5, 8'hC0);
      rd(4'h5);
      rd(4'h4);
      wr(4'h6, 8'h00);
      wr(4'h5, 8'hC0);

      // PA7 edge detector, rising polarity.
      wr(4'h7, 8'h01);
      wr(4'h6, 8'h40);
      rd(4'h7);
      pa_i = 8'hBC;
      repeat (5) rd(4'h5);
      wr(4'h5, 8'h40);
      repeat (2) rd(4'h5);
      pa_i = 8'h3C;
      repeat (6) rd(4'h5);
      // Falling polarity.
      wr(4'h7, 8'h00);
      pa_i = 8'hBC;
      repeat (4) rd(4'h5);
      pa_i = 8'h3C;
      repeat (4) rd(4'h5);

      // Deselected writes and reads to every address.
      for (int i = 0; i < 16; i++) bus(1'b0, 1'b0, 4'(i), 8'($urandom));
      for (int i = 0; i < 16; i++) bus(1'b0, 1'b1, 4'(i), 8'($urandom));
      for (int i = 0; i < 8; i++) rd(4'(i));

      // Randomised traffic.
      for (int i = 0; i < 1200; i++) begin
         int         r;
         logic [3:0] a;
         logic [7:0] d;
         r = int'($urandom_range(0, 9));
         a = 4'($urandom_range(0, 15));
         d = 8'($urandom);
         if ($urandom_range(0, 7) == 0) pa_i = 8'($urandom);
         if ($urandom_range(0, 7) == 0) pb_i = 8'($urandom);
         if (r < 5)      rd(a);
         else if (r < 9) wr(a, d);
         else            bus(1'b0, 1'($urandom), a, d);
      end

      idle();
      cs_i = 1'b0;
      repeat (2) @(posedge clk_i);
      if (sb_q.size() != 0) begin
         bad++;
         total++;
         $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/as65_riot.md
# as65_riot

Memory-mapped peripheral that answers bus cycles issued by the as65x CPU core. It provides two 8-bit bidirectional ports with direction registers, an 8-bit interval timer with selectable prescale, and a PA7 edge detector. Both the timer and the edge detector can raise an active-low IRQ that feeds the CPU's IRQn pad. It sits on the CPU's address/data bus behind an external chip-select decode and completes one bus transaction per `clk_i` cycle.

## Interface
Parameters:
- none

Ports:
- `clk_i` in 1: bus clock. All state updates on its rising edge.
- `rst_i` in 1: asynchronous, active-high reset.
- `cs_i` in 1: chip select. The current cycle is addressed to this block.
- `rwn_i` in 1: 1 = read, 0 = write.
- `a_i` in 4: register address.
- `d_i` in 8: write data.
- `d_o` out 8: read data.
- `d_oe` out 1: read-data drive enable.
- `pa_i` in 8: port A pad inputs (asynchronous).
- `pa_o` out 8: port A output register.
- `pa_oe` out 8: port A output enables.
- `pb_i` in 8: port B pad inputs.
- `pb_o` out 8: port B output register.
- `pb_oe` out 8: port B output enables.
- `irq_n_o` out 1: active-low interrupt request.

## Operation
Input synchronisation:
- `pa_i` and `pb_i` pass through two-flop synchronisers (`pa_s`, `pb_s`).
- A third flop on PA7 (`pa7_d`) provides the edge-detect history.

Reads:
- `d_oe = cs_i & rwn_i`, combinational.
- `d_o` is a combinational mux on `a_i`:
  - 0: `(DDRA & ORA) | (~DDRA & pa_s)`
  - 1: DDRA
  - 2: `(DDRB & ORB) | (~DDRB & pb_s)`
  - 3: DDRB
  - 4: TIMER
  - 5: IFR `{TF, EF, 6'b0}`
  - 6: IER `{TE, EE, 6'b0}`
  - 7: EDGE `{7'b0, POL}`
  - 8–F: TIMER
- Reads have no side effects.

Writes, committed at the rising edge when `cs_i & ~rwn_i`:
- 0: ORA
- 1: DDRA
- 2: ORB
- 3: DDRB
- 4: ignored
- 5: write-1-to-clear. `d_i[7]` clears TF; `d_i[6]` clears EF.
- 6: IER. TE = `d_i[7]`, EE = `d_i[6]`.
- 7: POL = `d_i[0]` (1 = rising edge, 0 = falling edge).
- 8–B: ignored.
- C–F: timer load. TIMER = `d_i`; prescale N selected by `a_i[1:0]` = 1, 8, 64, 1024; prescale counter PC = 0; RUN = 1; TF = 0.

Port outputs:
- `pa_o` = ORA, `pa_oe` = DDRA.
- `pb_o` = ORB, `pb_oe` = DDRB.

Timer, active only while RUN = 1. Each edge without a load:
- If PC == N-1: PC ← 0 and TIMER decrements. Otherwise PC increments.
- PC is 10 bits wide.
- Underflow (decrement from 0x00): TIMER ← 0xFF, TF ← 1, and N is forced to 1 until the next load. The timer then keeps free-running at clock rate.

Edge flag:
- EF ← 1 when `pa_s[7]` ≠ `pa7_d`, in the direction selected by POL.

Interrupt:
- `irq_n_o = ~((TF & TE) | (EF & EE))`, combinational from registers.

Priority on the same edge:
- A timer load beats a decrement or underflow. TF clears.
- A flag set beats a W1C clear of the same flag.
- A change to POL takes effect for comparisons starting at the next edge.

Reset (`rst_i` high, asynchronous, at any time including mid-count):
- ORA, DDRA, ORB, DDRB = 0x00.
- TIMER = 0x00, PC = 0, N = 1024, RUN = 0.
- TF = EF = TE = EE = 0, POL = 0.
- Synchronisers and `pa7_d` = 0.
- Resulting outputs: `pa_o`/`pa_oe`/`pb_o`/`pb_oe` = 0x00, `irq_n_o` = 1, `d_oe` = `cs_i & rwn_i`.

## Timing
- Register write: visible on `d_o` and port outputs in the cycle after edge T.
- Read: `d_o` valid in the same cycle that `cs_i`/`a_i` are valid.
- Timer load at edge T with N and value D: the k-th decrement occurs at edge T + k·N (k = 1..D). Underflow occurs at edge T + (D+1)·N. Subsequent decrements occur every edge.
- TF and `irq_n_o` change at the underflow edge.
- Pad to port read: a pin stable before edge E reads through port data at E+2.
- PA7 edge to EF: a transition stable before edge E sets EF at edge E+2. `irq_n_o` falls at the same edge when EE = 1.

## Test plan
- Reset mid-count (TIMER = 0x40, RUN = 1), then release. Required: TIMER reads 0x00, RUN = 0 (no decrement for 2000 cycles), IFR = 0x00, `irq_n_o` = 1, all port outputs and enables = 0x00.
- DDRA = 0xF0, ORA = 0xA5, `pa_i` = 0x3C, wait 2 cycles, read addr 0. Required: 0xAC, `pa_oe` = 0xF0, `pa_o` = 0xA5.
- Write 0x03 to addr 0xD (N = 8) at edge T, and set IER = 0x80. Required: TIMER reads 2/1/0 after T+8, T+16, T+24. TIMER = 0xFF with IFR = 0x80 and `irq_n_o` = 0 after T+32. 0xFE after T+33.
- Timer load at the underflow edge. Required: TIMER = new value, TF = 0.
- W1C of TF on the underflow edge. Required: TF = 1.
- POL = 1, IER = 0x40, drive PA7 0→1. Required: IFR = 0x40 two edges later and `irq_n_o` = 0. Write 0x40 to addr 5. Required: IFR = 0x00, `irq_n_o` = 1. A 1→0 transition on PA7 leaves EF = 0.
- `cs_i` = 0 with write strobes to every address. Required: no register changes, `d_oe` = 0.
